// File: rtl/memory_access_unit_if.sv
// Data-bus connection between the memory-stage master and a word-addressed slave.
// Handshake: the master holds address, strobe, byteenable and writedata stable while
// data_waitrequest=1; the transfer completes on the first rising edge with data_waitrequest=0.
interface memory_access_unit_if;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_waitrequest;

  modport master (
    output data_address, data_read, data_write, data_byteenable, data_writedata,
    input  data_readdata, data_waitrequest
  );

  modport slave (
    input  data_address, data_read, data_write, data_byteenable, data_writedata,
    output data_readdata, data_waitrequest
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage bus master: turns loads/stores into aligned word transactions with byte
// enables, stalls the pipeline during the access and returns an extended load result.
module memory_access_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memory_to_register_memory,
  input  logic                        memory_write_memory,
  input  logic [1:0]                  access_size_memory,
  input  logic                        load_signed_memory,
  input  logic [31:0]                 ALU_output_memory,
  input  logic [31:0]                 write_data_memory,
  output logic                        stall_memory,
  output logic [31:0]                 read_data_memory,
  output logic                        memory_done,
  output logic                        address_error,
  output logic                        timeout_error,
  output logic [1:0]                  debug_state,
  memory_access_unit_if.master        bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  offset_q, offset_d;

  logic        request;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign request = memory_to_register_memory | memory_write_memory;

  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wd_new     = write_data_memory;
    case (access_size_memory)
      2'b00: begin
        be_new = 4'b0001 << ALU_output_memory[1:0];
        wd_new = {4{write_data_memory[7:0]}};
      end
      2'b01: begin
        misaligned = ALU_output_memory[0];
        be_new     = ALU_output_memory[1] ? 4'b1100 : 4'b0011;
        wd_new     = {2{write_data_memory[15:0]}};
      end
      default: misaligned = |ALU_output_memory[1:0];
    endcase
  end

  // Lane extraction uses the offset captured at issue, since the pipeline inputs may move on.
  always_comb begin
    case (offset_q)
      2'd0:    byte_sel = bus.data_readdata[7:0];
      2'd1:    byte_sel = bus.data_readdata[15:8];
      2'd2:    byte_sel = bus.data_readdata[23:16];
      default: byte_sel = bus.data_readdata[31:24];
    endcase
    half_sel = offset_q[1] ? bus.data_readdata[31:16] : bus.data_readdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.data_readdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    read_d        = read_q;
    write_d       = write_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wd_d          = wd_q;
    rdata_d       = rdata_q;
    timeout_d     = 1'b0;
    is_load_d     = is_load_q;
    size_d        = size_q;
    signed_d      = signed_q;
    offset_d      = offset_q;
    stall_memory  = 1'b0;
    address_error = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (misaligned) begin
            address_error = 1'b1;
          end else begin
            stall_memory = 1'b1;
            state_d      = ACCESS;
            cnt_d        = 8'd0;
            addr_d       = {ALU_output_memory[31:2], 2'b00};
            be_d         = be_new;
            wd_d         = wd_new;
            // A simultaneous load and store is treated as a store only.
            read_d       = memory_to_register_memory & ~memory_write_memory;
            write_d      = memory_write_memory;
            is_load_d    = memory_to_register_memory & ~memory_write_memory;
            size_d       = access_size_memory;
            signed_d     = load_signed_memory;
            offset_d     = ALU_output_memory[1:0];
          end
        end
      end
      ACCESS: begin
        stall_memory = 1'b1;
        if (!bus.data_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (is_load_q) rdata_d = load_ext;
          state_d = DONE;
        end else if (cnt_q == WAIT_LAST) begin
          read_d    = 1'b0;
          write_d   = 1'b0;
          if (is_load_q) rdata_d = 32'd0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wd_q      <= 32'd0;
      rdata_q   <= 32'd0;
      timeout_q <= 1'b0;
      is_load_q <= 1'b0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      offset_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wd_q      <= wd_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      is_load_q <= is_load_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      offset_q  <= offset_d;
    end
  end

  assign memory_done         = (state_q == DONE);
  assign timeout_error       = timeout_q;
  assign read_data_memory    = rdata_q;
  assign debug_state         = state_q;
  assign bus.data_address    = addr_q;
  assign bus.data_read       = read_q;
  assign bus.data_write      = write_q;
  assign bus.data_byteenable = be_q;
  assign bus.data_writedata  = wd_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: driver task issues accesses, a bus slave model
// inserts wait states, and two monitors check bus transactions and done responses.
module tb_memory_access_unit;

  logic        clk;
  logic        reset;
  logic        memory_to_register_memory;
  logic        memory_write_memory;
  logic [1:0]  access_size_memory;
  logic        load_signed_memory;
  logic [31:0] ALU_output_memory;
  logic [31:0] write_data_memory;
  logic        stall_memory;
  logic [31:0] read_data_memory;
  logic        memory_done;
  logic        address_error;
  logic        timeout_error;
  logic [1:0]  debug_state;

  memory_access_unit_if bus ();

  memory_access_unit #(.MAX_WAIT(16)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .memory_to_register_memory (memory_to_register_memory),
    .memory_write_memory       (memory_write_memory),
    .access_size_memory        (access_size_memory),
    .load_signed_memory        (load_signed_memory),
    .ALU_output_memory         (ALU_output_memory),
    .write_data_memory         (write_data_memory),
    .stall_memory              (stall_memory),
    .read_data_memory          (read_data_memory),
    .memory_done               (memory_done),
    .address_error             (address_error),
    .timeout_error             (timeout_error),
    .debug_state               (debug_state),
    .bus                       (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {timeout_error, read_data_memory} expected at each done pulse
  logic [32:0] exp_q[$];
  // {address, byteenable, writedata, read, write} expected at each strobe rise
  logic [69:0] bus_q[$];

  int wait_cfg  = 0;
  int wait_seen = 0;

  task automatic check(input string nm, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // bus slave: holds waitrequest for wait_cfg cycles of each transfer
  always @(negedge clk) begin
    if (bus.data_read || bus.data_write) begin
      bus.data_waitrequest = (wait_seen < wait_cfg);
      wait_seen++;
    end else begin
      bus.data_waitrequest = 1'b0;
      wait_seen = 0;
    end
  end

  // bus monitor
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    logic        strobe;
    logic [69:0] e;
    strobe = bus.data_read | bus.data_write;
    if (reset && strobe && !prev_strobe) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected", {bus.data_address, bus.data_byteenable, bus.data_writedata,
              bus.data_read, bus.data_write}, 70'd0);
      end else begin
        e = bus_q.pop_front();
        check("bus_txn", {bus.data_address, bus.data_byteenable, bus.data_writedata,
              bus.data_read, bus.data_write}, e);
      end
    end
    prev_strobe = strobe;
  end

  // done monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && memory_done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 70'(memory_done), 70'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_result", {timeout_error, read_data_memory}, e);
      end
    end
  end

  task automatic clear_inputs();
    memory_to_register_memory = 1'b0;
    memory_write_memory       = 1'b0;
    access_size_memory        = 2'b00;
    load_signed_memory        = 1'b0;
    ALU_output_memory         = 32'd0;
    write_data_memory         = 32'd0;
  endtask

  // driver: issue one request and measure stall / strobe / latency
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int nwait, input logic exp_aerr,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic exp_to, input logic [31:0] exp_rd,
                        input int exp_stall, input int exp_strobe, input int exp_lat);
    int stall_cnt;
    int strobe_cnt;
    int lat;
    stall_cnt  = 0;
    strobe_cnt = 0;
    lat        = -1;
    @(negedge clk);
    memory_to_register_memory = ld;
    memory_write_memory       = st;
    access_size_memory        = sz;
    load_signed_memory        = sg;
    ALU_output_memory         = addr;
    write_data_memory         = wd;
    bus.data_readdata         = rd;
    wait_cfg                  = nwait;
    if (!exp_aerr) begin
      bus_q.push_back({exp_addr, exp_be, exp_wd, ld & ~st, st});
      exp_q.push_back({exp_to, exp_rd});
    end
    #1;
    check({nm, "_address_error"}, 70'(address_error), 70'(exp_aerr));
    for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      stall_cnt  += int'(stall_memory);
      strobe_cnt += int'(bus.data_read | bus.data_write);
      if (memory_done) lat = cyc;
      if (exp_aerr && cyc == 0) clear_inputs();
      if (exp_aerr && cyc == 3) break;
    end
    clear_inputs();
    check({nm, "_stall_cycles"},  70'(stall_cnt),  70'(exp_stall));
    check({nm, "_strobe_cycles"}, 70'(strobe_cnt), 70'(exp_strobe));
    check({nm, "_latency"},       70'(lat),        70'(exp_lat));
  endtask

  initial begin
    clear_inputs();
    bus.data_readdata = 32'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset_outputs", {stall_memory, read_data_memory, memory_done, address_error,
          timeout_error, debug_state}, 70'd0);
    check("reset_bus", {bus.data_address, bus.data_read, bus.data_write,
          bus.data_byteenable, bus.data_writedata}, 70'd0);

    //     name       ld    st    sz     sg    addr          wd            rd            wait aerr  exp_addr      be       exp_wd        to    exp_rd        stl str lat
    run_op("lw_wait", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2,  1'b0, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF, 4, 3, 4);
    run_op("sb_103",  1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0,  1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF, 2, 1, 2);
    run_op("lh_s",    1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'h8001_1234, 0,  1'b0, 32'h0000_0200, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001, 2, 1, 2);
    run_op("lh_u",    1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        32'h8001_1234, 0,  1'b0, 32'h0000_0200, 4'b1100, 32'h0,        1'b0, 32'h0000_8001, 2, 1, 2);
    run_op("lb_s",    1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0301, 32'h0,        32'h0000_8000, 0,  1'b0, 32'h0000_0300, 4'b0010, 32'h0,        1'b0, 32'hFFFF_FF80, 2, 1, 2);
    run_op("lb_u",    1'b1, 1'b0, 2'b11 & 2'b00, 1'b0, 32'h0000_0302, 32'h0, 32'h00C3_0000, 0,  1'b0, 32'h0000_0300, 4'b0100, 32'h0,        1'b0, 32'h0000_00C3, 2, 1, 2);
    run_op("sh_206",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'hFFFF_BEEF, 32'h0,        0,  1'b0, 32'h0000_0204, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0000_00C3, 2, 1, 2);
    run_op("sw_wait", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,        1,  1'b0, 32'h0000_0010, 4'b1111, 32'h1234_5678, 1'b0, 32'h0000_00C3, 3, 2, 3);
    run_op("ld_st",   1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h1111_1111, 0,  1'b0, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0000_00C3, 2, 1, 2);
    run_op("lw_mis",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        0, 0, -1);
    run_op("lh_mis",  1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0201, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        0, 0, -1);
    run_op("sw11",    1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0044, 32'h0102_0304, 32'h0,        0,  1'b0, 32'h0000_0044, 4'b1111, 32'h0102_0304, 1'b0, 32'h0000_00C3, 2, 1, 2);
    run_op("lw_tout", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'h7777_7777, 1000, 1'b0, 32'h0000_0040, 4'b1111, 32'h0,      1'b1, 32'h0,        17, 16, 17);
    run_op("lw_after",1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0048, 32'h0,        32'h0A0B_0C0D, 0,  1'b0, 32'h0000_0048, 4'b1111, 32'h0,        1'b0, 32'h0A0B_0C0D, 2, 1, 2);

    // reset in the middle of a stalled store
    @(negedge clk);
    memory_write_memory = 1'b1;
    access_size_memory  = 2'b10;
    ALU_output_memory   = 32'h0000_0080;
    write_data_memory   = 32'h5555_AAAA;
    wait_cfg            = 1000;
    bus_q.push_back({32'h0000_0080, 4'b1111, 32'h5555_AAAA, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid_in_access", 70'(debug_state), 70'd1);
    clear_inputs();
    reset    = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    #1;
    check("rst_mid_strobes", {bus.data_read, bus.data_write, memory_done, debug_state}, 70'd0);
    check("rst_mid_read_data", 70'(read_data_memory), 70'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    run_op("lw_post", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'h0,        32'h0BAD_F00D, 0,  1'b0, 32'h0000_0084, 4'b1111, 32'h0,        1'b0, 32'h0BAD_F00D, 2, 1, 2);

    repeat (3) @(negedge clk);
    check("done_queue_empty", 70'(exp_q.size()), 70'd0);
    check("bus_queue_empty",  70'(bus_q.size()), 70'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
